// File: rtl/program_ram_loader.sv
// program_ram_loader
//   Program RAM that the operator fills from the board switches. The CPU fetches
//   instructions from it through the fetch port, and the CPU fetches only while the
//   block is in RUN. In LOAD the CPU is held. Each debounced button press writes one
//   word at an address that advances after every write. When the block leaves load
//   mode it sends cpuReset, so the PC restarts at 0.
//
//   Ports:
//     clk          system clock (divided CPU clock)
//     reset        synchronous, active-high reset
//     loadMode     raw switch, 1 = LOAD, 0 = RUN (synchronised here)
//     loadStrobe   raw push button (synchronised and debounced here)
//     dataIn       word written in the WRITE cycle
//     cpuAddrIn    CPU fetch address (PC)
//     cpuDataOut   registered instruction to the decoder
//     cpuHold      1 = CPU must not advance
//     cpuReset     one-cycle pulse when returning to RUN from any load state
//     loadAddrOut  next write address (LED display)
//     full         sticky, set once the last address has been written
module program_ram_loader #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMode,
  input  logic                  loadStrobe,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] cpuAddrIn,
  output logic [DATA_WIDTH-1:0] cpuDataOut,
  output logic                  cpuHold,
  output logic                  cpuReset,
  output logic [ADDR_WIDTH-1:0] loadAddrOut,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LOAD,
    ST_DEBOUNCE,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   mode_meta_reg;
  logic                   mode_s_reg;
  logic                   strobe_meta_reg;
  logic                   strobe_s_reg;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  // Two-flop synchronisers for the asynchronous switch and button.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_meta_reg   <= 1'b0;
      mode_s_reg      <= 1'b0;
      strobe_meta_reg <= 1'b0;
      strobe_s_reg    <= 1'b0;
    end else begin
      mode_meta_reg   <= loadMode;
      mode_s_reg      <= mode_meta_reg;
      strobe_meta_reg <= loadStrobe;
      strobe_s_reg    <= strobe_meta_reg;
    end
  end

  // The RAM write port has no reset, so reset leaves the contents intact.
  // Reads happen only in RUN and writes only in WRITE, so the two never collide.
  always_ff @(posedge clk) begin
    if (state_reg == ST_WRITE) begin
      mem[loadAddrOut] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      cnt_reg     <= '0;
      cpuDataOut  <= '0;
      cpuHold     <= 1'b0;
      cpuReset    <= 1'b0;
      loadAddrOut <= '0;
      full        <= 1'b0;
    end else begin
      cpuReset   <= 1'b0;
      cpuDataOut <= '0;
      case (state_reg)
        ST_RUN: begin
          cpuDataOut <= mem[cpuAddrIn];
          cpuHold    <= 1'b0;
          if (mode_s_reg) begin
            state_reg   <= ST_LOAD;
            loadAddrOut <= '0;
            full        <= 1'b0;
            cpuHold     <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (!mode_s_reg) begin
            state_reg <= ST_RUN;
            cpuHold   <= 1'b0;
            cpuReset  <= 1'b1;
          end else if (strobe_s_reg) begin
            // The cycle that first sees the button counts as high cycle number 1.
            cnt_reg   <= CNT_W'(1);
            state_reg <= (DEBOUNCE_CYCLES <= 1) ? ST_WRITE : ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          // A mode drop wins over any button activity in the same cycle.
          if (!mode_s_reg) begin
            state_reg <= ST_RUN;
            cpuHold   <= 1'b0;
            cpuReset  <= 1'b1;
          end else if (!strobe_s_reg) begin
            state_reg <= ST_LOAD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              state_reg <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          loadAddrOut <= loadAddrOut + ADDR_WIDTH'(1);
          if (&loadAddrOut) begin
            full <= 1'b1;
          end
          state_reg <= ST_RELEASE;
        end

        ST_RELEASE: begin
          // A held button produces one write. The FSM waits here until the button is released.
          if (!mode_s_reg) begin
            state_reg <= ST_RUN;
            cpuHold   <= 1'b0;
            cpuReset  <= 1'b1;
          end else if (!strobe_s_reg) begin
            state_reg <= ST_LOAD;
          end
        end

        default: begin
          state_reg <= ST_RUN;
          cpuHold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_ram_loader.sv
// Testbench for program_ram_loader.
//   - A reference model tracks three things:
//       * the effect of the mode switch, which arrives a fixed 2-edge latency after the
//         switch is sampled;
//       * the RAM contents;
//       * the write pointer and the full flag.
//   - A compare process checks cpuHold, cpuReset and cpuDataOut against the model
//     on every cycle.
//   - Directed tests add literal checks that pin down the expected values.
module tb_program_ram_loader;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadMode;
  logic       loadStrobe;
  logic [3:0] dataIn;
  logic [3:0] cpuAddrIn;
  logic [3:0] cpuDataOut;
  logic       cpuHold;
  logic       cpuReset;
  logic [3:0] loadAddrOut;
  logic       full;

  program_ram_loader #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(4),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .loadMode(loadMode),
    .loadStrobe(loadStrobe),
    .dataIn(dataIn),
    .cpuAddrIn(cpuAddrIn),
    .cpuDataOut(cpuDataOut),
    .cpuHold(cpuHold),
    .cpuReset(cpuReset),
    .loadAddrOut(loadAddrOut),
    .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] mem_m [16];
  bit         known_m [16];
  int         addr_m = 0;
  int         full_m = 0;

  bit         mq0 = 0, mq1 = 0;     // recent loadMode samples
  bit         hold_e = 0, rst_e = 0, hold_n;
  logic [3:0] dout_e = '0;
  bit         dout_known = 0;
  bit         model_valid = 0;

  // Hold follows the switch two edges late. The block returns to RUN when hold
  // falls, and that is the cycle cpuReset pulses. Fetch data is the RAM word at
  // the address seen on the previous RUN edge, or 0 while the CPU is held.
  always @(posedge clk) begin
    if (reset) begin
      mq0 = 0; mq1 = 0;
      hold_e = 0; rst_e = 0;
      dout_e = '0; dout_known = 1;
      model_valid = 1;
    end else begin
      hold_n     = mq1;
      dout_known = hold_e ? 1'b1 : known_m[cpuAddrIn];
      dout_e     = hold_e ? 4'h0 : mem_m[cpuAddrIn];
      rst_e      = hold_e && !hold_n;
      hold_e     = hold_n;
      mq1        = mq0;
      mq0        = loadMode;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_cpuHold", int'(cpuHold), int'(hold_e));
      check("cyc_cpuReset", int'(cpuReset), int'(rst_e));
      if (dout_known) check("cyc_cpuDataOut", int'(cpuDataOut), int'(dout_e));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int len, input logic [3:0] d);
    dataIn     = d;
    loadStrobe = 1'b1;
    tick(len);
    loadStrobe = 1'b0;
    tick(8);
    if (len >= DEB) begin
      mem_m[addr_m]   = d;
      known_m[addr_m] = 1'b1;
      if (addr_m == 15) full_m = 1;
      addr_m = (addr_m + 1) % 16;
    end
    $display("press len=%0d data=%0h loadAddrOut=%0d full=%0b", len, d, loadAddrOut, full);
    check("press_loadAddrOut", int'(loadAddrOut), addr_m);
    check("press_full", int'(full), full_m);
  endtask

  task automatic enter_load();
    loadMode = 1'b1;
    tick(5);
    addr_m = 0;
    full_m = 0;
    $display("enter LOAD cpuHold=%0b", cpuHold);
    check("enter_cpuHold", int'(cpuHold), 1);
    check("enter_loadAddrOut", int'(loadAddrOut), 0);
    check("enter_full", int'(full), 0);
  endtask

  task automatic exit_load();
    int pulses;
    pulses   = 0;
    loadMode = 1'b0;
    repeat (8) begin
      tick(1);
      if (cpuReset) pulses++;
    end
    $display("exit LOAD cpuReset_pulses=%0d cpuHold=%0b", pulses, cpuHold);
    check("exit_cpuReset_pulses", pulses, 1);
    check("exit_cpuHold", int'(cpuHold), 0);
  endtask

  task automatic read(input logic [3:0] a, input logic [3:0] exp);
    cpuAddrIn = a;
    tick(1);
    $display("read addr=%0d data=%0h", a, cpuDataOut);
    check("read_data", int'(cpuDataOut), int'(exp));
  endtask

  logic [3:0] pre [16];

  initial begin
    pre = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h4};
    for (int i = 0; i < 16; i++) known_m[i] = 1'b0;

    reset      = 1'b1;
    loadMode   = 1'b0;
    loadStrobe = 1'b0;
    dataIn     = 4'h0;
    cpuAddrIn  = 4'h0;
    tick(3);
    $display("reset state hold=%0b creset=%0b dout=%0h addr=%0d full=%0b",
             cpuHold, cpuReset, cpuDataOut, loadAddrOut, full);
    check("rst_cpuHold", int'(cpuHold), 0);
    check("rst_cpuReset", int'(cpuReset), 0);
    check("rst_cpuDataOut", int'(cpuDataOut), 0);
    check("rst_loadAddrOut", int'(loadAddrOut), 0);
    check("rst_full", int'(full), 0);
    reset = 1'b0;
    tick(2);

    // Test 1: preload all 16 words (mem[3]=A), then fetch in RUN.
    enter_load();
    for (int i = 0; i < 16; i++) press(6, pre[i]);
    check("t1_full", int'(full), 1);
    check("t1_loadAddrOut_wrapped", int'(loadAddrOut), 0);
    exit_load();
    read(4'd3, 4'hA);
    read(4'd0, 4'h1);

    // Test 2: a long press writes exactly once.
    enter_load();
    press(6, 4'h5);
    check("t2_loadAddrOut", int'(loadAddrOut), 1);

    // Test 3: short glitches are rejected, and exactly DEB high cycles are accepted.
    press(2, 4'hC);
    check("t3_glitch2_loadAddrOut", int'(loadAddrOut), 1);
    press(3, 4'hC);
    check("t3_glitch3_loadAddrOut", int'(loadAddrOut), 1);
    press(4, 4'h7);
    check("t3_exact_loadAddrOut", int'(loadAddrOut), 2);
    exit_load();
    read(4'd0, 4'h5);
    read(4'd1, 4'h7);
    read(4'd2, 4'h3);

    // Test 4: 17 presses with data = press index cause wrap-around and set full.
    enter_load();
    for (int k = 0; k < 17; k++) begin
      press(6, 4'(k));
      if (k == 14) check("t4_full_before_last", int'(full), 0);
      if (k == 15) check("t4_full_after_16th", int'(full), 1);
    end
    check("t4_loadAddrOut", int'(loadAddrOut), 1);
    check("t4_full_sticky", int'(full), 1);

    // Test 5: return to RUN, and fetch resumes from the written program.
    exit_load();
    read(4'd0, 4'h0);
    read(4'd5, 4'h5);
    read(4'd15, 4'hF);

    // Test 6: reset during DEBOUNCE loses the pending write.
    enter_load();
    dataIn     = 4'h9;
    loadStrobe = 1'b1;
    tick(4);
    reset      = 1'b1;
    loadMode   = 1'b0;
    loadStrobe = 1'b0;
    tick(1);
    $display("reset in DEBOUNCE hold=%0b addr=%0d full=%0b", cpuHold, loadAddrOut, full);
    check("t6_cpuHold", int'(cpuHold), 0);
    check("t6_loadAddrOut", int'(loadAddrOut), 0);
    check("t6_full", int'(full), 0);
    reset = 1'b0;
    tick(3);
    read(4'd0, 4'h0);
    read(4'd1, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
